// File: rtl/fetch_pc_sequencer.sv
// Front-end PC sequencer: issues word fetches, buffers in-order responses, squashes on EXE redirect.
// Optional statistics counters enabled with FETCH_REDIRECT_STATS_EN.
module fetch_pc_sequencer #(
   parameter logic [31:0] RESET_PC        = 32'hBFC0_0000,
   parameter int          MAX_OUTSTANDING = 2,
   parameter int          CNT_W           = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             Request_Alt_PC,
   input  logic [31:0]      alt_addr,
   input  logic             flush,
   input  logic             STALL,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_gnt,
   input  logic             imem_rvalid,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      Instr_OUT,
   output logic [31:0]      Instr_PC_OUT,
   output logic             Instr_valid_OUT,
`ifdef FETCH_REDIRECT_STATS_EN
   output logic [CNT_W-1:0] redirect_count_OUT,
   output logic [CNT_W-1:0] dropped_count_OUT,
`endif
   output logic             squash_OUT
);

   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [CW-1:0] MAXC  = CW'(MAX_OUTSTANDING);
   localparam logic [PW-1:0] LASTP = PW'(MAX_OUTSTANDING - 1);

   typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

   state_t        r_state;
   logic [31:0]   r_fetchPc;
   logic [CW-1:0] r_outCnt;
   logic [CW-1:0] r_dropCnt;
   logic [CW-1:0] r_fifoCnt;
   logic [PW-1:0] r_fifoRd;
   logic [PW-1:0] r_fifoWr;
   logic [PW-1:0] r_pcqRd;
   logic [PW-1:0] r_pcqWr;
   logic [31:0]   r_fifoInstr [MAX_OUTSTANDING];
   logic [31:0]   r_fifoPc    [MAX_OUTSTANDING];
   logic [31:0]   r_pcq       [MAX_OUTSTANDING];
   logic          r_squash;

   logic          w_redirect;
   logic [31:0]   w_target;
   logic [CW:0]   w_inUse;
   logic          w_grant;
   logic          w_rspAcc;
   logic          w_dropActive;
   logic          w_push;
   logic          w_discard;
   logic          w_pop;
   logic          w_fifoFull;
   logic [CW-1:0] w_outCntNext;
   logic [CW-1:0] w_fifoCntNext;

   function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
      return (p == LASTP) ? '0 : p + PW'(1);
   endfunction

   // Responses with nothing tracked (owed from before reset) are ignored entirely.
   assign w_redirect    = Request_Alt_PC | flush;
   assign w_target      = {alt_addr[31:2], 2'b00};
   assign w_inUse       = {1'b0, r_outCnt} + {1'b0, r_fifoCnt};
   assign imem_req      = (r_state == RUN) && (w_inUse < {1'b0, MAXC}) && !w_redirect;
   assign imem_addr     = r_fetchPc;
   assign w_grant       = imem_req && imem_gnt;
   assign w_rspAcc      = imem_rvalid && (r_outCnt != '0);
   assign w_dropActive  = (r_dropCnt != '0);
   assign w_push        = w_rspAcc && !w_dropActive && !w_redirect;
   assign w_discard     = w_rspAcc && (w_dropActive || w_redirect);
   assign w_pop         = Instr_valid_OUT && !STALL && !w_redirect;
   assign w_fifoFull    = (r_fifoCnt == MAXC);
   assign w_outCntNext  = r_outCnt + CW'(w_grant) - CW'(w_rspAcc);
   assign w_fifoCntNext = r_fifoCnt + CW'(w_push) - CW'(w_pop);

   assign Instr_OUT       = r_fifoInstr[r_fifoRd];
   assign Instr_PC_OUT    = r_fifoPc[r_fifoRd];
   assign Instr_valid_OUT = (r_fifoCnt != '0);
   assign squash_OUT      = r_squash;

   // Sequencer state: one idle boot cycle, HOLD while decode is stalled on a full buffer.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state <= BOOT;
      end else if (w_redirect) begin
         r_state <= RUN;
      end else begin
         case (r_state)
            BOOT:    r_state <= RUN;
            RUN:     if (STALL && w_fifoFull) r_state <= HOLD;
            HOLD:    if (!STALL) r_state <= RUN;
            default: r_state <= BOOT;
         endcase
      end
   end

   // Fetch PC, in-flight count and the number of stale responses still to be thrown away.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_fetchPc <= RESET_PC;
         r_outCnt  <= '0;
         r_dropCnt <= '0;
         r_squash  <= 1'b0;
      end else begin
         r_outCnt <= w_outCntNext;
         r_squash <= w_redirect;
         if (w_redirect) begin
            r_fetchPc <= w_target;
            r_dropCnt <= w_outCntNext;
         end else begin
            if (w_grant) r_fetchPc <= r_fetchPc + 32'd4;
            if (w_rspAcc && w_dropActive) r_dropCnt <= r_dropCnt - CW'(1);
         end
      end
   end

   // PC shadow queue pairs each live response with the address it was fetched from.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_pcqRd <= '0;
         r_pcqWr <= '0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) r_pcq[i] <= '0;
      end else if (w_redirect) begin
         r_pcqRd <= '0;
         r_pcqWr <= '0;
      end else begin
         if (w_grant) begin
            r_pcq[r_pcqWr] <= r_fetchPc;
            r_pcqWr        <= nextPtr(r_pcqWr);
         end
         if (w_push) r_pcqRd <= nextPtr(r_pcqRd);
      end
   end

   // Response buffer; the head feeds decode directly, so a word appears the cycle after rvalid.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_fifoRd  <= '0;
         r_fifoWr  <= '0;
         r_fifoCnt <= '0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            r_fifoInstr[i] <= '0;
            r_fifoPc[i]    <= '0;
         end
      end else if (w_redirect) begin
         r_fifoRd  <= '0;
         r_fifoWr  <= '0;
         r_fifoCnt <= '0;
      end else begin
         if (w_push) begin
            r_fifoInstr[r_fifoWr] <= imem_rdata;
            r_fifoPc[r_fifoWr]    <= r_pcq[r_pcqRd];
            r_fifoWr              <= nextPtr(r_fifoWr);
         end
         if (w_pop) r_fifoRd <= nextPtr(r_fifoRd);
         r_fifoCnt <= w_fifoCntNext;
      end
   end

`ifdef FETCH_REDIRECT_STATS_EN
   logic [CNT_W-1:0] r_redirCount;
   logic [CNT_W-1:0] r_dropCount;

   // Saturating event counters for redirects and discarded responses.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_redirCount <= '0;
         r_dropCount  <= '0;
      end else begin
         if (w_redirect && (r_redirCount != '1)) r_redirCount <= r_redirCount + CNT_W'(1);
         if (w_discard && (r_dropCount != '1))   r_dropCount  <= r_dropCount + CNT_W'(1);
      end
   end

   assign redirect_count_OUT = r_redirCount;
   assign dropped_count_OUT  = r_dropCount;
`else
   logic w_unusedDiscard;
   assign w_unusedDiscard = w_discard;
`endif

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Randomized scoreboard bench for fetch_pc_sequencer: epoch-tagged expected stream plus in-order memory model.
module tb_fetch_pc_sequencer;

   localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
   localparam int          MAXO     = 2;
   localparam int          CNT_W    = 16;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        Request_Alt_PC = 1'b0;
   logic [31:0] alt_addr = '0;
   logic        flush = 1'b0;
   logic        STALL = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] Instr_OUT;
   logic [31:0] Instr_PC_OUT;
   logic        Instr_valid_OUT;
   logic        squash_OUT;
`ifdef FETCH_REDIRECT_STATS_EN
   logic [CNT_W-1:0] redirect_count_OUT;
   logic [CNT_W-1:0] dropped_count_OUT;
`endif

   always #5 CLK = ~CLK;

   fetch_pc_sequencer #(.RESET_PC(RESET_PC), .MAX_OUTSTANDING(MAXO), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RESET(RESET),
      .Request_Alt_PC(Request_Alt_PC), .alt_addr(alt_addr), .flush(flush), .STALL(STALL),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .Instr_OUT(Instr_OUT), .Instr_PC_OUT(Instr_PC_OUT), .Instr_valid_OUT(Instr_valid_OUT),
`ifdef FETCH_REDIRECT_STATS_EN
      .redirect_count_OUT(redirect_count_OUT), .dropped_count_OUT(dropped_count_OUT),
`endif
      .squash_OUT(squash_OUT)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
      int          epoch;
   } exp_t;

   exp_t        expQ[$];
   logic [31:0] memQ[$];
   int          checks = 0;
   int          failures = 0;
   int          epoch = 0;
   int          cycleNo = 0;
   logic [31:0] modelPc = RESET_PC;
   bit          monitorOn = 0;
   int          gntPct, rvPct, stallPct, redirPct;
   bit          forceRedirect = 0;
   logic [31:0] forceTarget = '0;
   bit          prevReqWait = 0;
   logic [31:0] prevAddr = '0;
   bit          wrapPending = 0;
   int          firstGrantCycle = -1;
   int          firstValidCycle = -1;
   bit          monPrevRedir = 0;
   bit          monCurRedir;

   function automatic logic [31:0] dataOf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, actual, expected, cycleNo);
      end
   endtask

   // Drive one cycle per iteration at the falling edge; memory returns granted words in order.
   task automatic applyStimulus(input int nCycles);
      bit          rd;
      bit          grant;
      logic [31:0] a;
      for (int c = 0; c < nCycles; c++) begin
         @(negedge CLK);
         cycleNo++;
         rd = forceRedirect || ($urandom_range(99) < redirPct);
         Request_Alt_PC = 1'b0;
         flush = 1'b0;
         if (rd) begin
            case ($urandom_range(2))
               0: Request_Alt_PC = 1'b1;
               1: flush = 1'b1;
               default: begin Request_Alt_PC = 1'b1; flush = 1'b1; end
            endcase
            if (forceRedirect) alt_addr = forceTarget;
            else if ($urandom_range(3) == 0) alt_addr = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
            else alt_addr = $urandom();
         end else begin
            alt_addr = $urandom();
         end
         forceRedirect = 0;
         STALL = ($urandom_range(99) < stallPct);
         imem_gnt = ($urandom_range(99) < gntPct);
         if (memQ.size() > 0 && $urandom_range(99) < rvPct) begin
            a = memQ.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata = dataOf(a);
         end else begin
            imem_rvalid = 1'b0;
            imem_rdata = $urandom();
         end
         #1;
         if (rd) checkOutput("req_on_redirect", 32'(imem_req), 32'd0);
         if (prevReqWait && !rd) begin
            checkOutput("req_held", 32'(imem_req), 32'd1);
            checkOutput("addr_held", imem_addr, prevAddr);
         end
         if (imem_req) checkOutput("fetch_addr", imem_addr, modelPc);
         if (wrapPending && imem_req && !rd) begin
            checkOutput("wrap_addr", imem_addr, 32'h0000_0000);
            wrapPending = 0;
         end
         grant = imem_req && imem_gnt;
         if (grant) begin
            if (firstGrantCycle < 0) firstGrantCycle = cycleNo;
            if (modelPc == 32'hFFFF_FFFC) wrapPending = 1;
            memQ.push_back(imem_addr);
            expQ.push_back('{pc: modelPc, data: dataOf(modelPc), epoch: epoch});
            modelPc = modelPc + 32'd4;
            checkOutput("in_flight_limit", 32'(memQ.size() <= MAXO), 32'd1);
         end
         if (rd) begin
            epoch++;
            modelPc = {alt_addr[31:2], 2'b00};
            wrapPending = 0;
         end
         prevReqWait = imem_req && !imem_gnt;
         prevAddr = imem_addr;
      end
   endtask

   // Monitor: compare presented words against the current-epoch head of the expected stream.
   initial begin
      forever begin
         @(negedge CLK);
         #2;
         monCurRedir = Request_Alt_PC | flush;
         if (monitorOn) begin
            checkOutput("squash_pulse", 32'(squash_OUT), 32'(monPrevRedir));
            if (!monCurRedir) begin
               while (expQ.size() > 0 && expQ[0].epoch != epoch) void'(expQ.pop_front());
               if (Instr_valid_OUT) begin
                  if (firstValidCycle < 0) firstValidCycle = cycleNo;
                  if (expQ.size() == 0) begin
                     checkOutput("unexpected_valid", 32'(Instr_valid_OUT), 32'd0);
                  end else begin
                     checkOutput("instr_pc", Instr_PC_OUT, expQ[0].pc);
                     checkOutput("instr_word", Instr_OUT, expQ[0].data);
                     if (!STALL) void'(expQ.pop_front());
                  end
               end
            end
         end
         monPrevRedir = monitorOn && monCurRedir;
      end
   end

   task automatic setKnobs(input int g, input int r, input int s, input int d);
      gntPct = g; rvPct = r; stallPct = s; redirPct = d;
   endtask

   initial begin
      int live;
      setKnobs(100, 100, 0, 0);
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      #1;
      checkOutput("reset_req", 32'(imem_req), 32'd0);
      checkOutput("reset_addr", imem_addr, RESET_PC);
      checkOutput("reset_instr", Instr_OUT, 32'd0);
      checkOutput("reset_pc", Instr_PC_OUT, 32'd0);
      checkOutput("reset_valid", 32'(Instr_valid_OUT), 32'd0);
      checkOutput("reset_squash", 32'(squash_OUT), 32'd0);
      @(negedge CLK);
      RESET = 1'b1;
      #1;
      checkOutput("boot_no_req", 32'(imem_req), 32'd0);
      monitorOn = 1;

      applyStimulus(20);
      checkOutput("first_valid_latency", 32'(firstValidCycle - firstGrantCycle), 32'd2);

      setKnobs(0, 100, 0, 0);
      applyStimulus(5);
      setKnobs(100, 100, 0, 0);
      applyStimulus(10);

      setKnobs(100, 0, 0, 0);
      applyStimulus(2);
      forceRedirect = 1; forceTarget = 32'h0040_0013;
      setKnobs(100, 100, 0, 0);
      applyStimulus(12);

      setKnobs(100, 100, 100, 0);
      applyStimulus(6);
      setKnobs(100, 100, 0, 0);
      applyStimulus(10);

      forceRedirect = 1; forceTarget = 32'hFFFF_FFF8;
      applyStimulus(10);

      setKnobs(100, 100, 0, 0);
      for (int k = 0; k < 20; k++) begin
         forceRedirect = 1; forceTarget = $urandom();
         applyStimulus(1);
         forceRedirect = 1; forceTarget = $urandom();
         applyStimulus($urandom_range(1, 4));
      end

      setKnobs(60, 60, 30, 8);
      applyStimulus(3000);
      setKnobs(90, 80, 60, 3);
      applyStimulus(2000);

      setKnobs(0, 100, 0, 0);
      applyStimulus(20);
      live = 0;
      foreach (expQ[i]) if (expQ[i].epoch == epoch) live++;
      checkOutput("drain_empty", 32'(live), 32'd0);
      checkOutput("drain_mem", 32'(memQ.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_pc_sequencer.md
Name: fetch_pc_sequencer

Overview:
Front-end PC sequencer and instruction-fetch handshake unit. It is the receiving end of the EXE-stage redirect interface: it consumes Request_Alt_PC, alt_addr and flush from EXE. It issues word fetches to the instruction memory, buffers returned words, and presents Instr/PC pairs to decode. On a redirect it squashes buffered and in-flight fetches and restarts at the target.

Parameters:
RESET_PC, 32'hBFC0_0000, first fetch address after reset
MAX_OUTSTANDING, 2, maximum un-consumed fetches (in flight plus buffered); also the response FIFO depth; range 1..4
CNT_W, 16, width of statistics counters (optional feature only)

Ports:
CLK  in  1  clock
RESET  in  1  asynchronous, active-low reset
Request_Alt_PC  in  1  EXE redirect request
alt_addr  in  32  redirect target
flush  in  1  EXE pipeline flush
STALL  in  1  decode cannot accept this cycle
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address, word aligned
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response valid; responses return in order
imem_rdata  in  32  response word
Instr_OUT  out  32  instruction to decode
Instr_PC_OUT  out  32  PC of Instr_OUT
Instr_valid_OUT  out  1  Instr_OUT/Instr_PC_OUT valid
squash_OUT  out  1  one-cycle pulse: younger pipeline state is squashed

Behaviour:
- Reset values:
  - imem_req=0, imem_addr=RESET_PC, Instr_OUT=0, Instr_PC_OUT=0, Instr_valid_OUT=0, squash_OUT=0.
  - Internal: fetch_pc=RESET_PC, out_cnt=0, drop_cnt=0, FIFO empty, state=BOOT.
  - Reset is legal mid-transaction. Responses owed at reset are not tracked; the memory is reset together with this block.
- State machine:
  - BOOT: one cycle, no request -> RUN.
  - RUN: issuing.
  - HOLD: entered when STALL=1 and FIFO full; returns to RUN when STALL=0.
- redirect = Request_Alt_PC | flush. Target = {alt_addr[31:2],2'b00}. flush alone also redirects to alt_addr.
- Request rules:
  - imem_req=1 in RUN when (out_cnt + fifo_count) < MAX_OUTSTANDING and no redirect this cycle.
  - imem_addr=fetch_pc.
  - While imem_req=1 and imem_gnt=0, imem_addr is held stable; imem_req may drop only on redirect.
  - On imem_req&imem_gnt: out_cnt+1; fetch_pc <= fetch_pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0).
- Response rules:
  - On imem_rvalid with drop_cnt>0: discard the word, drop_cnt-1, out_cnt-1.
  - Otherwise push {imem_rdata, PC} into the FIFO, out_cnt-1. PC comes from an in-order PC shadow queue of depth MAX_OUTSTANDING.
- Output:
  - FIFO head drives Instr_OUT/Instr_PC_OUT/Instr_valid_OUT combinationally from registered storage.
  - Pop when Instr_valid_OUT=1 and STALL=0.
  - Zero-latency bypass is not provided: minimum latency from rvalid to Instr_valid_OUT is 1 cycle.
- Redirect cycle:
  - FIFO and PC queue cleared; Instr_valid_OUT=0 from the next cycle.
  - drop_cnt <= out_cnt_next. This includes a request granted in the same cycle and excludes a response arriving in the same cycle, which is itself dropped if drop_cnt>0 or, if not yet counted, discarded.
  - fetch_pc <= target; first new request the following cycle; state -> RUN.
  - squash_OUT=1 the following cycle only.
- Back-to-back redirects: the second wins; drop_cnt recomputed from out_cnt_next.
- Redirect with STALL=1: still takes effect; STALL only blocks pops.
- out_cnt never exceeds MAX_OUTSTANDING, so the FIFO cannot overflow.

Optional Feature:
FETCH_REDIRECT_STATS_EN:
- Defined: adds outputs redirect_count_OUT[CNT_W-1:0] (increments per redirect cycle) and dropped_count_OUT[CNT_W-1:0] (increments per discarded response). Both reset to 0 and saturate at all-ones.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset, imem_gnt=1, rvalid 1 cycle after grant, STALL=0 -> imem_addr BFC00000, BFC00004, BFC00008...; Instr_PC_OUT same sequence, one per cycle, first valid 2 cycles after first grant.
- Hold imem_gnt=0 for 5 cycles -> imem_req=1, imem_addr stable at BFC00000 all 5 cycles; no fetch_pc advance.
- 2 requests in flight, pulse Request_Alt_PC=1 with alt_addr=00400013 -> squash_OUT pulse next cycle; both stale responses discarded (no Instr_valid_OUT); next imem_addr=00400010; first Instr_PC_OUT=00400010.
- STALL=1 for 6 cycles with MAX_OUTSTANDING=2 -> at most 2 grants, HOLD entered, Instr_OUT held constant; STALL=0 -> words delivered in order, fetch resumes.
- Redirect and rvalid in the same cycle, then another redirect one cycle later -> no stale word ever valid; out_cnt returns to 0; fetch starts at the second target.
- fetch_pc=FFFFFFFC with grant -> next imem_addr=00000000.
